// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter.
// Producer indices double as the cdb_src encoding seen by ROB and RS/LSB.
package cdb_arbiter_pkg;

  localparam int CDB_N_REQ      = 3;
  localparam int CDB_FIFO_DEPTH = 2;
  localparam int ROB_WIDTH_BIT  = 4;
  localparam int CDB_SRC_W      = 2;

  typedef enum logic [CDB_SRC_W-1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LSB = 2'd1,
    CDB_SRC_BR  = 2'd2
  } cdb_src_e;

  // Round-robin successor of a producer index, wrapping at n.
  function automatic logic [CDB_SRC_W-1:0] cdb_rr_next(input logic [CDB_SRC_W-1:0] ptr,
                                                       input int n);
    if (int'(ptr) + 1 >= n)
      return '0;
    return ptr + CDB_SRC_W'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-producer result FIFO. Freezes completely while stalled; a flush
// empties it and drops any same-cycle push or pop.
module cdb_arbiter_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   stall,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Full is judged before the edge, so a full FIFO rejects even when popping.
  assign w_push = push & ~full  & ~stall & ~flush;
  assign w_pop  = pop  & ~empty & ~stall & ~flush;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (!stall) begin
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push)
      r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-producer FIFOs, round-robin grant of one
// head per ready cycle onto a registered broadcast bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = CDB_N_REQ,
  parameter int DEPTH  = CDB_FIFO_DEPTH,
  parameter int TAG_W  = ROB_WIDTH_BIT,
  parameter int DATA_W = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    clear_all,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_value,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_value,
  output logic [1:0]              cdb_src
);

  localparam int W     = TAG_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [N_REQ-1:0]     w_full;
  logic [N_REQ-1:0]     w_empty;
  logic [N_REQ-1:0]     w_push;
  logic [N_REQ-1:0]     w_pop;
  logic [W-1:0]         w_dout  [N_REQ];
  logic [CNT_W-1:0]     w_count [N_REQ];

  logic                 w_grant_found;
  logic [CDB_SRC_W-1:0] w_grant_idx;
  logic [W-1:0]         w_grant_data;
  logic [CDB_SRC_W-1:0] w_scan_idx;

  logic                 r_cdb_valid;
  logic [TAG_W-1:0]     r_cdb_tag;
  logic [DATA_W-1:0]    r_cdb_value;
  cdb_src_e             r_cdb_src;
  logic [CDB_SRC_W-1:0] r_rr_ptr;

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    // Ready drops to 0 immediately under reset so producers never see a stale accept.
    assign req_ready[g] = rst_n_in & (w_count[g] != CNT_W'(DEPTH));
    assign w_push[g]    = req_valid[g] & ~w_full[g];
    assign w_pop[g]     = w_grant_found & (w_grant_idx == CDB_SRC_W'(g));

    cdb_arbiter_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
    ) u_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .push     (w_push[g]),
      .pop      (w_pop[g]),
      .flush    (clear_all),
      .stall    (~rdy_in),
      .din      ({req_tag[g*TAG_W +: TAG_W], req_value[g*DATA_W +: DATA_W]}),
      .dout     (w_dout[g]),
      .count    (w_count[g]),
      .full     (w_full[g]),
      .empty    (w_empty[g])
    );
  end

  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_grant_data  = '0;
    w_scan_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan_idx = CDB_SRC_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_grant_found && !w_empty[w_scan_idx]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_scan_idx;
        w_grant_data  = w_dout[w_scan_idx];
      end
    end
  end

  // Broadcast register: flush beats grant; pause freezes everything.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
      r_cdb_src   <= CDB_SRC_ALU;
      r_rr_ptr    <= '0;
    end else if (rdy_in) begin
      if (clear_all) begin
        r_cdb_valid <= 1'b0;
        r_rr_ptr    <= '0;
      end else if (w_grant_found) begin
        r_cdb_valid <= 1'b1;
        r_cdb_tag   <= w_grant_data[W-1 -: TAG_W];
        r_cdb_value <= w_grant_data[DATA_W-1:0];
        r_cdb_src   <= cdb_src_e'(w_grant_idx);
        r_rr_ptr    <= cdb_rr_next(w_grant_idx, N_REQ);
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_value = r_cdb_value;
  assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised bench for cdb_arbiter: queue-based reference model feeds a
// scoreboard that a negedge monitor drains against the broadcast bus.
module tb_cdb_arbiter;

  localparam int N     = 3;
  localparam int DEPTH = 2;
  localparam int TW    = 4;
  localparam int DW    = 32;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] value;
    logic [1:0]    src;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rdy_in;
  logic            clear_all;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_value;
  logic [1:0]      cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .rdy_in    (rdy_in),
    .clear_all (clear_all),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_value (req_value),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  ent_t mq [N][$];
  ent_t exp_q [$];
  int   rr;
  int   checks = 0;
  int   errors = 0;

  logic          d_rdy;
  logic          d_clr;
  logic          d_v   [N];
  logic [TW-1:0] d_tag [N];
  logic [DW-1:0] d_val [N];

  ent_t last_e;
  logic last_v = 1'b0;
  logic mon_rdy_edge = 1'b0;

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = d_v[i];
      req_tag[i*TW +: TW]     = d_tag[i];
      req_value[i*DW +: DW]   = d_val[i];
    end
    rdy_in    = d_rdy;
    clear_all = d_clr;
  endtask

  // Reference model: advance one clock edge using the inputs the bench drove.
  task automatic model_step();
    int   sz [N];
    int   g;
    int   idx;
    ent_t e;
    if (!d_rdy || !rst_n) return;
    for (int i = 0; i < N; i++) sz[i] = mq[i].size();
    if (d_clr) begin
      for (int i = 0; i < N; i++) begin
        if (d_v[i] && sz[i] < DEPTH) d_v[i] = 1'b0;
        mq[i].delete();
      end
      rr = 0;
      return;
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (g < 0 && sz[idx] > 0) g = idx;
    end
    if (g >= 0) begin
      exp_q.push_back(mq[g].pop_front());
      rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (d_v[i] && sz[i] < DEPTH) begin
        e.tag   = d_tag[i];
        e.value = d_val[i];
        e.src   = 2'(i);
        mq[i].push_back(e);
        d_v[i] = 1'b0;
      end
    end
  endtask

  task automatic gen_inputs(input int p_rdy, input int p_clr, input int p_val);
    d_rdy = ($urandom_range(0, 99) < p_rdy);
    d_clr = ($urandom_range(0, 99) < p_clr);
    for (int i = 0; i < N; i++) begin
      if (!d_v[i] && $urandom_range(0, 99) < p_val) begin
        d_v[i]   = 1'b1;
        d_tag[i] = TW'($urandom);
        d_val[i] = $urandom;
      end
    end
    apply();
  endtask

  task automatic check_ready();
    logic [N-1:0] exp_r;
    for (int i = 0; i < N; i++) exp_r[i] = (mq[i].size() < DEPTH);
    checks++;
    if (req_ready !== exp_r) begin
      errors++;
      $display("FAIL req_ready at %0t: got %b expected %b", $time, req_ready, exp_r);
    end
  endtask

  // Starts and ends 1ns after a rising edge.
  task automatic run_cycle(input int p_rdy, input int p_clr, input int p_val);
    gen_inputs(p_rdy, p_clr, p_val);
    #1;
    check_ready();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, want);
    end
  endtask

  always @(posedge clk) mon_rdy_edge = rdy_in && rst_n;

  // Monitor: a fresh broadcast after every ready edge, a frozen bus otherwise.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      checks++;
      if (mon_rdy_edge) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (cdb_valid !== 1'b1 || cdb_tag !== e.tag || cdb_value !== e.value || cdb_src !== e.src) begin
            errors++;
            $display("FAIL broadcast at %0t: got v=%b tag=%0d val=0x%0h src=%0d expected v=1 tag=%0d val=0x%0h src=%0d",
                     $time, cdb_valid, cdb_tag, cdb_value, cdb_src, e.tag, e.value, e.src);
          end
          last_e = e;
          last_v = 1'b1;
        end else begin
          if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle at %0t: got cdb_valid=%b tag=%0d src=%0d expected cdb_valid=0",
                     $time, cdb_valid, cdb_tag, cdb_src);
          end
          last_v = 1'b0;
        end
      end else begin
        if (cdb_valid !== last_v ||
            (last_v && (cdb_tag !== last_e.tag || cdb_value !== last_e.value || cdb_src !== last_e.src))) begin
          errors++;
          $display("FAIL pause_hold at %0t: got v=%b tag=%0d src=%0d expected v=%b tag=%0d src=%0d",
                   $time, cdb_valid, cdb_tag, cdb_src, last_v, last_e.tag, last_e.src);
        end
      end
    end
  end

  int p_rdy_t [4] = '{100, 100, 60, 90};
  int p_clr_t [4] = '{0,   0,   0,  5};
  int p_val_t [4] = '{30,  95,  70, 60};

  initial begin
    rr    = 0;
    d_rdy = 1'b1;
    d_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      d_v[i]   = 1'b1;
      d_tag[i] = TW'(i + 1);
      d_val[i] = 32'hA000 + i;
    end
    rst_n = 1'b0;
    apply();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_cdb_valid", {31'd0, cdb_valid}, 0);
    check_val("reset_cdb_tag",   {28'd0, cdb_tag}, 0);
    check_val("reset_cdb_value", cdb_value, 0);
    check_val("reset_cdb_src",   {30'd0, cdb_src}, 0);
    check_val("reset_req_ready", {29'd0, req_ready}, 0);
    rst_n = 1'b1;

    // Entries held through reset are accepted right after release.
    repeat (10) run_cycle(100, 0, 0);

    // Lone ALU result: visible one edge after the grant edge, then bus idles.
    d_v[0] = 1'b1; d_tag[0] = 4'd5; d_val[0] = 32'h1234;
    run_cycle(100, 0, 0);
    run_cycle(100, 0, 0);
    check_val("single_valid", {31'd0, cdb_valid}, 1);
    check_val("single_tag",   {28'd0, cdb_tag}, 5);
    check_val("single_value", cdb_value, 32'h1234);
    check_val("single_src",   {30'd0, cdb_src}, 0);
    run_cycle(100, 0, 0);
    check_val("single_idle",  {31'd0, cdb_valid}, 0);

    for (int ph = 0; ph < 4; ph++)
      repeat (500) run_cycle(p_rdy_t[ph], p_clr_t[ph], p_val_t[ph]);

    // Load up, then reset asynchronously mid-operation.
    repeat (6) run_cycle(100, 0, 100);
    rst_n = 1'b0;
    #1;
    check_val("midreset_valid", {31'd0, cdb_valid}, 0);
    check_val("midreset_ready", {29'd0, req_ready}, 0);
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_q.delete();
    rr     = 0;
    last_v = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (300) run_cycle(85, 3, 60);
    repeat (12) run_cycle(100, 0, 0);
    check_val("drain_valid", {31'd0, cdb_valid}, 0);
    check_val("drain_ready", {29'd0, req_ready}, 32'h7);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
